adat_rx_output_interface: RTL and testbench
===========================================

Name: adat_rx_output_interface

Overview:
Back-end of the ADAT receiver: collects decoded 24-bit channel words (ch0..ch7) from the frame decoder into an 8-channel parallel sample frame. Classifies sample rate from the measured frame period, generates a word clock, and reports lock. Sits after the bit/frame decoder; feeds the user-facing audio interface.

Parameters:
LOCK_FRAMES, 4, consecutive good frames required before o_locked asserts
T48_MIN, 1946, lowest i_frame_time classified as 48 kHz
T48_MAX, 2138, highest i_frame_time classified as 48 kHz
T44_MIN, 2139, lowest i_frame_time classified as 44.1 kHz
T44_MAX, 2340, highest i_frame_time classified as 44.1 kHz
TIMEOUT_CYC, 4096, cycles without data_valid before lock drops (optional feature only)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_frame_time  in  12  measured frame period in i_clk cycles
i_data  in  24  decoded channel word
i_channel  in  3  channel index of i_data
i_data_valid  in  1  i_data/i_channel qualifier, one cycle per word
i_sync  in  1  upstream frame-sync detected
o_sample_rate  out  SampleRate (adat_rx_adat_pkg)  SampleRate_Unknown / SampleRate_Rate44_1kHz / SampleRate_Rate48kHz
o_word_clk  out  1  frame-rate square wave
o_channels  out  8x24  latched frame, unpacked [0:7]
o_valid  out  1  one-cycle pulse: new frame on o_channels
o_locked  out  1  stream locked

Behaviour:
- Reset (i_rst=1 at edge): o_channels all 0, o_valid 0, o_locked 0, o_word_clk 0, o_sample_rate Unknown, expected-channel counter 0, good-frame counter 0, shadow regs 0.
- Rate classification, registered, 1-cycle latency: i_sync=0 -> Unknown; T48_MIN<=i_frame_time<=T48_MAX -> 48 kHz; T44_MIN..T44_MAX -> 44.1 kHz; else Unknown. Unsigned 12-bit compares.
- Capture: on i_data_valid, i_data written to shadow[i_channel]. If i_channel==expected, expected increments (wraps 7->0); else frame error: expected <- (i_channel==0 ? 1 : 0), good-frame counter <- 0, no o_valid for that frame.
- Frame complete: i_data_valid with i_channel==7 and expected==7 -> next cycle o_channels <= {shadow[0..6], i_data}, o_valid=1 for exactly one cycle. o_channels held otherwise.
- Lock: on each complete frame with i_sync=1 and rate != Unknown, good-frame counter increments (saturates at LOCK_FRAMES); o_locked=1 when counter==LOCK_FRAMES, registered same cycle as o_valid. Counter and o_locked cleared on: frame error, i_sync=0, or rate Unknown.
- Word clock: on frame-complete cycle o_word_clk<=1 and half-period counter loads i_frame_time>>1; counter decrements each cycle; at 0 o_word_clk<=0. New frame before expiry reloads and keeps high.
- Simultaneous i_sync falling and ch7: lock clears, o_valid still pulses.
- i_data_valid=0 cycles between words are ignored (no timeout unless optional feature).

Optional Feature:
ADAT_RX_OUTPUT_TIMEOUT_EN: defined -> watchdog counts cycles since last i_data_valid; reaching TIMEOUT_CYC clears o_locked, good-frame counter, expected counter; o_sample_rate forced Unknown until next valid word. Undefined -> no watchdog, TIMEOUT_CYC unused.

Test Plan:
- Reset then idle, i_frame_time=2048, i_sync=1 -> all outputs 0/Unknown during reset; o_sample_rate=48 kHz 1 cycle after release.
- 5 frames ch0..7, data {8'hAA,8'h00,ch} back-to-back, 1 idle cycle between frames -> o_valid pulses 1 cycle after each ch7; o_channels[k]=24'hAA000k; o_locked=1 after 4th frame; rate 48 kHz.
- i_frame_time=2229 -> 44.1 kHz; 1500 and 3000 -> Unknown; locked frames stop counting, o_locked drops.
- Out-of-order sequence 0,1,3,... -> no o_valid for that frame, o_locked 0, recovery after 4 clean frames.
- i_sync dropped mid-stream for 1 cycle -> o_locked 0, rate Unknown; relock after 4 frames.
- o_word_clk high for 1024 cycles after frame completion at i_frame_time=2048, then low; with ADAT_RX_OUTPUT_TIMEOUT_EN, 4096 idle cycles -> o_locked 0.

Source files
------------

// File: rtl/adat_rx_output_interface.sv
// ADAT receiver back-end: assembles 8-channel frames, classifies sample rate, word clock and lock.
// Optional watchdog on missing data: define ADAT_RX_OUTPUT_TIMEOUT_EN.
package adat_rx_adat_pkg;
    typedef enum logic [1:0] {
        SampleRate_Unknown     = 2'd0,
        SampleRate_Rate44_1kHz = 2'd1,
        SampleRate_Rate48kHz   = 2'd2
    } SampleRate;
endpackage

module adat_rx_output_interface
    import adat_rx_adat_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned T48_MIN     = 1946,
    parameter int unsigned T48_MAX     = 2138,
    parameter int unsigned T44_MIN     = 2139,
    parameter int unsigned T44_MAX     = 2340
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_frame_time,
    input  logic [23:0] i_data,
    input  logic [2:0]  i_channel,
    input  logic        i_data_valid,
    input  logic        i_sync,
    output SampleRate   o_sample_rate,
    output logic        o_word_clk,
    output logic [23:0] o_channels [0:7],
    output logic        o_valid,
    output logic        o_locked
);
    localparam int unsigned FTW = 12;
    localparam int unsigned DW  = 24;
    localparam int unsigned CW  = $clog2(LOCK_FRAMES + 1);
    localparam logic [FTW-1:0] T48_LO   = FTW'(T48_MIN);
    localparam logic [FTW-1:0] T48_HI   = FTW'(T48_MAX);
    localparam logic [FTW-1:0] T44_LO   = FTW'(T44_MIN);
    localparam logic [FTW-1:0] T44_HI   = FTW'(T44_MAX);
    localparam logic [CW-1:0]  LOCK_CNT = CW'(LOCK_FRAMES);

    SampleRate          rate_q, rate_d;
    logic [2:0]         exp_q, exp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               valid_q, valid_d;
    logic               wclk_q, wclk_d;
    logic [FTW-1:0]     half_q, half_d;
    logic [DW-1:0]      shadow_q [0:6];
    logic [DW-1:0]      shadow_d [0:6];
    logic [DW-1:0]      chans_q [0:7];
    logic [DW-1:0]      chans_d [0:7];
    logic               frame_done;
    logic               frame_err;

`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYC);
    logic [WW-1:0]      wdog_q, wdog_d;
    logic               tmo_q, tmo_d;
    logic               tmo_hit;
`endif

    always_comb begin
        rate_d     = SampleRate_Unknown;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        locked_d   = locked_q;
        valid_d    = 1'b0;
        wclk_d     = wclk_q;
        half_d     = half_q;
        shadow_d   = shadow_q;
        chans_d    = chans_q;
        frame_err  = 1'b0;
        frame_done = 1'b0;
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
        wdog_d  = wdog_q;
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        if (i_data_valid) begin
            wdog_d = '0;
            tmo_d  = 1'b0;
        end else if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + WW'(1);
        end
        if (!i_data_valid && wdog_d == WDOG_MAX) begin
            tmo_hit = 1'b1;
            tmo_d   = 1'b1;
        end
`endif

        if (!i_sync) begin
            rate_d = SampleRate_Unknown;
        end else if (i_frame_time >= T48_LO && i_frame_time <= T48_HI) begin
            rate_d = SampleRate_Rate48kHz;
        end else if (i_frame_time >= T44_LO && i_frame_time <= T44_HI) begin
            rate_d = SampleRate_Rate44_1kHz;
        end
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
        if (tmo_d) rate_d = SampleRate_Unknown;
`endif

        // Channel 7 never needs a shadow; it goes straight into the output frame.
        if (i_data_valid) begin
            for (int k = 0; k < 7; k++) begin
                if (i_channel == 3'(k)) shadow_d[k] = i_data;
            end
            if (i_channel == exp_q) begin
                exp_d = exp_q + 3'd1;
            end else begin
                frame_err = 1'b1;
                exp_d     = (i_channel == 3'd0) ? 3'd1 : 3'd0;
            end
        end

        frame_done = i_data_valid && (i_channel == 3'd7) && (exp_q == 3'd7);
        if (frame_done) begin
            for (int k = 0; k < 7; k++) chans_d[k] = shadow_q[k];
            chans_d[7] = i_data;
            valid_d    = 1'b1;
            if (cnt_q != LOCK_CNT) cnt_d = cnt_q + CW'(1);
        end

        if (frame_err || !i_sync || rate_q == SampleRate_Unknown) cnt_d = '0;
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
        if (tmo_hit) begin
            cnt_d = '0;
            exp_d = '0;
        end
`endif
        locked_d = (cnt_d == LOCK_CNT);

        // Word clock stays high for half the measured frame period after each frame.
        if (frame_done) begin
            wclk_d = 1'b1;
            half_d = i_frame_time >> 1;
        end else if (half_q != '0) begin
            half_d = half_q - FTW'(1);
            if (half_q == FTW'(1)) wclk_d = 1'b0;
        end else begin
            wclk_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rate_q   <= SampleRate_Unknown;
            exp_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            wclk_q   <= 1'b0;
            half_q   <= '0;
            shadow_q <= '{default: '0};
            chans_q  <= '{default: '0};
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            rate_q   <= rate_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            wclk_q   <= wclk_d;
            half_q   <= half_d;
            shadow_q <= shadow_d;
            chans_q  <= chans_d;
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
            wdog_q   <= wdog_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign o_sample_rate = rate_q;
    assign o_word_clk    = wclk_q;
    assign o_channels    = chans_q;
    assign o_valid       = valid_q;
    assign o_locked      = locked_q;

endmodule

// File: tb/tb_adat_rx_output_interface.sv
// Directed self-checking bench for adat_rx_output_interface.
module tb_adat_rx_output_interface;
    import adat_rx_adat_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [11:0] i_frame_time = 12'd2048;
    logic [23:0] i_data = '0;
    logic [2:0]  i_channel = '0;
    logic        i_data_valid = 1'b0;
    logic        i_sync = 1'b1;
    SampleRate   o_sample_rate;
    logic        o_word_clk;
    logic [23:0] o_channels [0:7];
    logic        o_valid;
    logic        o_locked;

    int checks = 0;
    int errors = 0;

    logic [11:0] ft_tab   [8] = '{12'd2138, 12'd2139, 12'd2340, 12'd1946,
                                  12'd2341, 12'd1945, 12'd1500, 12'd3000};
    SampleRate   rate_tab [8] = '{SampleRate_Rate48kHz, SampleRate_Rate44_1kHz,
                                  SampleRate_Rate44_1kHz, SampleRate_Rate48kHz,
                                  SampleRate_Unknown, SampleRate_Unknown,
                                  SampleRate_Unknown, SampleRate_Unknown};
    logic [2:0]  ooo_seq  [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    adat_rx_output_interface dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_time  (i_frame_time),
        .i_data        (i_data),
        .i_channel     (i_channel),
        .i_data_valid  (i_data_valid),
        .i_sync        (i_sync),
        .o_sample_rate (o_sample_rate),
        .o_word_clk    (o_word_clk),
        .o_channels    (o_channels),
        .o_valid       (o_valid),
        .o_locked      (o_locked)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_word(input logic [2:0] ch, input logic [23:0] d);
        i_data_valid = 1'b1;
        i_channel    = ch;
        i_data       = d;
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic frame_std();
        for (int c = 0; c < 8; c++) send_word(3'(c), 24'hAA0000 | 24'(c));
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_valid !== 1'b0 || o_locked !== 1'b0 || o_word_clk !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid=%b locked=%b wclk=%b want 0 0 0", o_valid, o_locked, o_word_clk);
        end
        checks++;
        if (o_sample_rate !== SampleRate_Unknown) begin
            errors++;
            $display("FAIL reset_rate got %0d want %0d", o_sample_rate, SampleRate_Unknown);
        end
        checks++;
        if (o_channels[3] !== 24'h0) begin
            errors++;
            $display("FAIL reset_channels got %h want 000000", o_channels[3]);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_sample_rate !== SampleRate_Rate48kHz) begin
            errors++;
            $display("FAIL rate_after_reset got %0d want %0d", o_sample_rate, SampleRate_Rate48kHz);
        end
    endtask

    task automatic test_frames();
        for (int f = 0; f < 5; f++) begin
            frame_std();
            checks++;
            if (o_valid !== 1'b1) begin
                errors++;
                $display("FAIL frame%0d_valid got %b want 1", f, o_valid);
            end
            checks++;
            if (o_locked !== (f >= 3)) begin
                errors++;
                $display("FAIL frame%0d_locked got %b want %b", f, o_locked, (f >= 3));
            end
            if (f == 0) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (o_channels[k] !== (24'hAA0000 | 24'(k))) begin
                        errors++;
                        $display("FAIL channel%0d got %h want %h", k, o_channels[k], 24'hAA0000 | 24'(k));
                    end
                end
            end
            tick();
            checks++;
            if (o_valid !== 1'b0 || o_channels[7] !== 24'hAA0007) begin
                errors++;
                $display("FAIL frame%0d_idle got valid=%b ch7=%h want 0 aa0007", f, o_valid, o_channels[7]);
            end
        end
        checks++;
        if (o_sample_rate !== SampleRate_Rate48kHz) begin
            errors++;
            $display("FAIL frames_rate got %0d want %0d", o_sample_rate, SampleRate_Rate48kHz);
        end
    endtask

    task automatic test_rate();
        i_frame_time = 12'd2229;
        tick();
        checks++;
        if (o_sample_rate !== SampleRate_Rate44_1kHz || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL rate_2229 got rate=%0d locked=%b want 1 1", o_sample_rate, o_locked);
        end
        for (int i = 0; i < 8; i++) begin
            i_frame_time = ft_tab[i];
            tick();
            checks++;
            if (o_sample_rate !== rate_tab[i]) begin
                errors++;
                $display("FAIL rate_ft%0d got %0d want %0d", ft_tab[i], o_sample_rate, rate_tab[i]);
            end
        end
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL rate_unknown_unlock got %b want 0", o_locked);
        end
        frame_std();
        checks++;
        if (o_valid !== 1'b1 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL unknown_rate_frame got valid=%b locked=%b want 1 0", o_valid, o_locked);
        end
        tick();
        i_frame_time = 12'd2048;
        tick();
    endtask

    task automatic test_out_of_order();
        for (int i = 0; i < 7; i++) send_word(ooo_seq[i], 24'hAA0000 | 24'(ooo_seq[i]));
        checks++;
        if (o_valid !== 1'b0 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL ooo_frame got valid=%b locked=%b want 0 0", o_valid, o_locked);
        end
        tick();
        for (int f = 0; f < 4; f++) begin
            frame_std();
            checks++;
            if (o_valid !== 1'b1 || o_locked !== (f == 3)) begin
                errors++;
                $display("FAIL ooo_recover%0d got valid=%b locked=%b want 1 %b", f, o_valid, o_locked, (f == 3));
            end
            tick();
        end
    endtask

    task automatic test_sync_drop();
        for (int c = 0; c < 4; c++) send_word(3'(c), 24'hAA0000 | 24'(c));
        i_sync = 1'b0;
        tick();
        i_sync = 1'b1;
        checks++;
        if (o_locked !== 1'b0 || o_sample_rate !== SampleRate_Unknown) begin
            errors++;
            $display("FAIL sync_drop got locked=%b rate=%0d want 0 %0d", o_locked, o_sample_rate, SampleRate_Unknown);
        end
        for (int c = 4; c < 8; c++) send_word(3'(c), 24'hAA0000 | 24'(c));
        checks++;
        if (o_valid !== 1'b1 || o_locked !== 1'b0 || o_sample_rate !== SampleRate_Rate48kHz) begin
            errors++;
            $display("FAIL sync_resume got valid=%b locked=%b rate=%0d want 1 0 %0d",
                     o_valid, o_locked, o_sample_rate, SampleRate_Rate48kHz);
        end
        tick();
        for (int f = 0; f < 3; f++) begin
            frame_std();
            checks++;
            if (o_locked !== (f == 2)) begin
                errors++;
                $display("FAIL sync_relock%0d got %b want %b", f, o_locked, (f == 2));
            end
            tick();
        end
    endtask

    task automatic test_sync_ch7();
        for (int c = 0; c < 7; c++) send_word(3'(c), 24'h123450 + 24'(c));
        i_sync = 1'b0;
        send_word(3'd7, 24'h123457);
        i_sync = 1'b1;
        checks++;
        if (o_valid !== 1'b1 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL sync_ch7 got valid=%b locked=%b want 1 0", o_valid, o_locked);
        end
        checks++;
        if (o_channels[6] !== 24'h123456 || o_channels[7] !== 24'h123457) begin
            errors++;
            $display("FAIL sync_ch7_data got %h %h want 123456 123457", o_channels[6], o_channels[7]);
        end
        tick();
        tick();
    endtask

    task automatic test_word_clk();
        int n;
        frame_std();
        n = 0;
        while (o_word_clk === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL word_clk_high got %0d cycles want 1024", n);
        end
        tick();
        checks++;
        if (o_word_clk !== 1'b0) begin
            errors++;
            $display("FAIL word_clk_low got %b want 0", o_word_clk);
        end
    endtask

`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
    task automatic test_timeout();
        for (int f = 0; f < 4; f++) begin
            frame_std();
            tick();
        end
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_prelock got %b want 1", o_locked);
        end
        repeat (4100) tick();
        checks++;
        if (o_locked !== 1'b0 || o_sample_rate !== SampleRate_Unknown) begin
            errors++;
            $display("FAIL timeout got locked=%b rate=%0d want 0 %0d", o_locked, o_sample_rate, SampleRate_Unknown);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_rate();
        test_out_of_order();
        test_sync_drop();
        test_sync_ch7();
        test_word_clk();
`ifdef ADAT_RX_OUTPUT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
